// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and sizes (result select encoding, widths).
// Latency: n/a, declarations only.
// Backpressure: n/a, declarations only.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Write-back result source; 2'b11 is reserved and decodes as ALU.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

endpackage

// File: rtl/result_mux.sv
// Pure 3:1 result selector (ALU / load data / PC+4), shared with forwarding.
// Latency: combinational, zero cycles.
// Backpressure: none; output always follows inputs.
import riscv_pkg::*;

module result_mux #(
    parameter int WIDTH = XLEN
) (
    input  result_src_t      sel,
    input  logic [WIDTH-1:0] alu_dat,
    input  logic [WIDTH-1:0] mem_dat,
    input  logic [WIDTH-1:0] pc4_dat,
    output logic [WIDTH-1:0] result_dat
);

    // Reserved encoding falls to ALU so the result is never X.
    always_comb begin
        result_dat = alu_dat;
        case (sel)
            RES_MEM: result_dat = mem_dat;
            RES_PC4: result_dat = pc4_dat;
            default: result_dat = alu_dat;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// RV32I write-back stage: result select, 32x32 register file, commit counter.
// Latency: Result_W/RD*_D combinational; writes visible one edge later. Optional
// write-through when REGFILE_BYPASS_EN is defined. Backpressure: none (bubbles = RegWrite_W low).
import riscv_pkg::*;

module writeback_regfile #(
    parameter int WIDTH = XLEN,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite_W,
    input  logic [1:0]            ResultSrc_W,
    input  logic [WIDTH-1:0]      ALUResult_W,
    input  logic [WIDTH-1:0]      ReadData_W,
    input  logic [WIDTH-1:0]      PCP4_W,
    input  logic [REG_ADDR_W-1:0] Rd_W,
    input  logic [REG_ADDR_W-1:0] Rs1_D,
    input  logic [REG_ADDR_W-1:0] Rs2_D,
    output logic [WIDTH-1:0]      RD1_D,
    output logic [WIDTH-1:0]      RD2_D,
    output logic [WIDTH-1:0]      Result_W,
    output logic [WIDTH-1:0]      WbCount
);

    // x0 is not stored; the array starts at x1.
    logic [WIDTH-1:0] regs [1:NREGS-1];
    logic [WIDTH-1:0] wb_count_q;
    logic             commit;

    result_mux #(.WIDTH(WIDTH)) u_result_mux (
        .sel        (result_src_t'(ResultSrc_W)),
        .alu_dat    (ALUResult_W),
        .mem_dat    (ReadData_W),
        .pc4_dat    (PCP4_W),
        .result_dat (Result_W)
    );

    assign commit  = RegWrite_W && (Rd_W != '0);
    assign WbCount = wb_count_q;

    // Commit the selected result; reset clears every stored register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && (int'(Rd_W) < NREGS)) begin
            regs[Rd_W] <= Result_W;
        end
    end

    // Count committed writes; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_q <= '0;
        end else if (commit) begin
            wb_count_q <= wb_count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Read port A: x0 and out-of-range read as zero.
    always_comb begin
        RD1_D = '0;
        if ((Rs1_D != '0) && (int'(Rs1_D) < NREGS)) begin
            RD1_D = regs[Rs1_D];
        end
`ifdef REGFILE_BYPASS_EN
        // Write-through: gated by rst_n so reads stay zero during reset.
        if (rst_n && commit && (Rd_W == Rs1_D)) begin
            RD1_D = Result_W;
        end
`endif
    end

    // Read port B: same rules as port A.
    always_comb begin
        RD2_D = '0;
        if ((Rs2_D != '0) && (int'(Rs2_D) < NREGS)) begin
            RD2_D = regs[Rs2_D];
        end
`ifdef REGFILE_BYPASS_EN
        if (rst_n && commit && (Rd_W == Rs2_D)) begin
            RD2_D = Result_W;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with an expected-value queue.
// Latency: checks taken 1 time unit after edges / input changes.
// Backpressure: n/a.
`timescale 1ns/1ps

module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [31:0] ALUResult_W, ReadData_W, PCP4_W;
    logic [4:0]  Rd_W, Rs1_D, Rs2_D;
    logic [31:0] RD1_D, RD2_D, Result_W, WbCount;

    // Narrow instance used only to reach the counter wrap in few cycles.
    logic        s_we;
    logic [7:0]  s_rd1, s_rd2, s_res, s_cnt;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
        .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W), .PCP4_W(PCP4_W),
        .Rd_W(Rd_W), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .Result_W(Result_W), .WbCount(WbCount)
    );

    writeback_regfile #(.WIDTH(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .RegWrite_W(s_we), .ResultSrc_W(2'b00),
        .ALUResult_W(8'h5A), .ReadData_W(8'h00), .PCP4_W(8'h00),
        .Rd_W(5'd1), .Rs1_D(5'd1), .Rs2_D(5'd0),
        .RD1_D(s_rd1), .RD2_D(s_rd2), .Result_W(s_res), .WbCount(s_cnt)
    );

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite_W = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; RegWrite_W = 1'b0; ResultSrc_W = 2'b00;
        ALUResult_W = '0; ReadData_W = '0; PCP4_W = '0;
        Rd_W = '0; Rs1_D = '0; Rs2_D = '0; s_we = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        Rs1_D = 5'd5; Rs2_D = 5'd31;
        expect_val(32'h0); expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
        #1;
        check("reset_rd1", RD1_D);
        check("reset_rd2", RD2_D);
        check("reset_cnt", WbCount);
        check("reset_cnt_small", {24'h0, s_cnt});

        // Load-data write to x3
        RegWrite_W = 1'b1; Rd_W = 5'd3; ResultSrc_W = 2'b01;
        ReadData_W = 32'hDEADBEEF; ALUResult_W = 32'h1; PCP4_W = 32'h200;
        expect_val(32'hDEADBEEF);
        #1 check("mux_mem", Result_W);
        step(); idle(); Rs1_D = 5'd3;
        expect_val(32'hDEADBEEF); expect_val(32'd1);
        #1 check("x3_read", RD1_D);
        check("cnt_after_x3", WbCount);

        // Other select codes, no commit
        ResultSrc_W = 2'b00; expect_val(32'h1);
        #1 check("mux_alu", Result_W);
        ResultSrc_W = 2'b11; expect_val(32'h1);
        #1 check("mux_reserved", Result_W);

        // PC+4 write to x4
        RegWrite_W = 1'b1; Rd_W = 5'd4; ResultSrc_W = 2'b10; PCP4_W = 32'h104;
        expect_val(32'h104);
        #1 check("mux_pc4", Result_W);
        step(); idle(); Rs2_D = 5'd4;
        expect_val(32'h104); expect_val(32'd2); expect_val(32'hDEADBEEF);
        #1 check("x4_read", RD2_D);
        check("cnt_after_x4", WbCount);
        check("x3_still", RD1_D);

        // Write to x0 is dropped
        RegWrite_W = 1'b1; Rd_W = 5'd0; ResultSrc_W = 2'b00; ALUResult_W = 32'hFFFF_FFFF;
        Rs1_D = 5'd0;
        expect_val(32'h0);
        #1 check("x0_same_cycle", RD1_D);
        step(); idle();
        expect_val(32'h0); expect_val(32'd2);
        #1 check("x0_read", RD1_D);
        check("cnt_x0_unchanged", WbCount);

        // Same-cycle write/read of x7
        RegWrite_W = 1'b1; Rd_W = 5'd7; ResultSrc_W = 2'b00; ALUResult_W = 32'h11;
        step();
        ALUResult_W = 32'h22; Rs2_D = 5'd7;
`ifdef REGFILE_BYPASS_EN
        expect_val(32'h22);
`else
        expect_val(32'h11);
`endif
        #1 check("x7_same_cycle", RD2_D);
        step(); idle();
        expect_val(32'h22); expect_val(32'd4);
        #1 check("x7_next_cycle", RD2_D);
        check("cnt_after_x7", WbCount);

        // Async reset mid-stream
        RegWrite_W = 1'b1; Rd_W = 5'd9; ALUResult_W = 32'hA5A5A5A5;
        step(); idle(); Rs1_D = 5'd9;
        expect_val(32'hA5A5A5A5);
        #1 check("x9_read", RD1_D);
        rst_n = 1'b0;
        RegWrite_W = 1'b1; Rd_W = 5'd10; ALUResult_W = 32'h77; Rs2_D = 5'd10;
        expect_val(32'h0); expect_val(32'h0); expect_val(32'h77); expect_val(32'h0);
        #1 check("rst_rd1_async", RD1_D);
        check("rst_cnt_async", WbCount);
        check("rst_result_comb", Result_W);
        check("rst_rd2_during", RD2_D);
        step();
        rst_n = 1'b1; idle();
        expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
        #1 check("post_rst_x10", RD2_D);
        check("post_rst_x9", RD1_D);
        check("post_rst_cnt", WbCount);

        // First write after release
        RegWrite_W = 1'b1; Rd_W = 5'd10; ALUResult_W = 32'h55;
        step(); idle();
        expect_val(32'h55); expect_val(32'd1);
        #1 check("first_write_x10", RD2_D);
        check("first_write_cnt", WbCount);

        // Counter wrap on the 8-bit instance
        s_we = 1'b1;
        for (int i = 0; i < 255; i++) step();
        expect_val(32'hFF);
        check("small_cnt_max", {24'h0, s_cnt});
        step();
        s_we = 1'b0;
        expect_val(32'h00); expect_val(32'h5A);
        #1 check("small_cnt_wrap", {24'h0, s_cnt});
        check("small_x1_read", {24'h0, s_rd1});

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
